// File: rtl/n64_pi_read_sequencer.sv
// N64 PI cart-side read sequencer: syncs ALE/READ strobes, latches the bus address, serves prefetched ROM words.
// Optional N64_PI_RANGE_CHECK_EN: addresses outside the ROM window read as 0000 without fetching.
module n64_pi_read_sequencer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [31:0] ROM_BASE      = 32'h1000_0000,
  parameter int unsigned ROM_SIZE_LOG2 = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] n64_ad_i,
  input  logic        n64_ale_h,
  input  logic        n64_ale_l,
  input  logic        n64_read_n,
  output logic [15:0] n64_ad_o,
  output logic        n64_ad_oe,
  output logic [31:0] rom_addr,
  output logic        rom_req,
  input  logic        rom_ack,
  input  logic [15:0] rom_data,
  output logic        late_read
);
  localparam int unsigned LAST = SYNC_STAGES - 1;

  typedef enum logic [2:0] {IDLE, ADDR, FETCH, READY, DRIVE, HOLD} state_t;

  if (SYNC_STAGES < 2 || ROM_SIZE_LOG2 > 32 || ROM_BASE[0] != 1'b0) begin : g_bad_cfg
    $error("n64_pi_read_sequencer: invalid parameter set");
  end

`ifdef N64_PI_RANGE_CHECK_EN
  localparam logic [32:0] WIN = 33'(1) << ROM_SIZE_LOG2;

  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - ROM_BASE;
    return ({1'b0, off} < WIN);
  endfunction
`endif

  logic [LAST:0] ale_h_s, ale_l_s, read_n_s;
  logic [15:0]   ad_pipe [SYNC_STAGES];
  logic          ale_h_d, ale_l_d, read_n_d;
  logic          ev_h_rise, ev_h_fall, ev_l_fall, ev_r_fall, ev_r_rise;
  logic [15:0]   ad_ev;

  // Synchronisers, AD pipeline of equal depth, and registered edge events with the aligned AD word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ale_h_s   <= '0;
      ale_l_s   <= '0;
      read_n_s  <= '0;
      ale_h_d   <= 1'b0;
      ale_l_d   <= 1'b0;
      read_n_d  <= 1'b0;
      ev_h_rise <= 1'b0;
      ev_h_fall <= 1'b0;
      ev_l_fall <= 1'b0;
      ev_r_fall <= 1'b0;
      ev_r_rise <= 1'b0;
      ad_ev     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) ad_pipe[i] <= '0;
    end else begin
      ale_h_s    <= {ale_h_s[LAST-1:0], n64_ale_h};
      ale_l_s    <= {ale_l_s[LAST-1:0], n64_ale_l};
      read_n_s   <= {read_n_s[LAST-1:0], n64_read_n};
      ad_pipe[0] <= n64_ad_i;
      for (int i = 1; i < SYNC_STAGES; i++) ad_pipe[i] <= ad_pipe[i-1];
      ale_h_d   <= ale_h_s[LAST];
      ale_l_d   <= ale_l_s[LAST];
      read_n_d  <= read_n_s[LAST];
      ev_h_rise <= ale_h_s[LAST] & ~ale_h_d;
      ev_h_fall <= ~ale_h_s[LAST] & ale_h_d;
      ev_l_fall <= ~ale_l_s[LAST] & ale_l_d;
      ev_r_fall <= ~read_n_s[LAST] & read_n_d;
      ev_r_rise <= read_n_s[LAST] & ~read_n_d;
      ad_ev     <= ad_pipe[LAST];
    end
  end

  state_t      state, state_nxt;
  logic [31:0] addr, addr_nxt, rom_addr_nxt;
  logic [15:0] data_reg, data_nxt, ad_o_nxt;
  logic        read_pend, pend_nxt, oe_nxt, req_nxt, late_nxt;
  logic        start_fetch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      data_reg  <= '0;
      read_pend <= 1'b0;
      n64_ad_o  <= '0;
      n64_ad_oe <= 1'b0;
      rom_addr  <= '0;
      rom_req   <= 1'b0;
      late_read <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      data_reg  <= data_nxt;
      read_pend <= pend_nxt;
      n64_ad_o  <= ad_o_nxt;
      n64_ad_oe <= oe_nxt;
      rom_addr  <= rom_addr_nxt;
      rom_req   <= req_nxt;
      late_read <= late_nxt;
    end
  end

  // Next-state and next-output logic; ale_h rising pre-empts everything
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    data_nxt     = data_reg;
    pend_nxt     = read_pend;
    ad_o_nxt     = n64_ad_o;
    oe_nxt       = n64_ad_oe;
    rom_addr_nxt = rom_addr;
    req_nxt      = rom_req;
    late_nxt     = late_read;
    start_fetch  = 1'b0;

    if (ev_h_rise) begin
      state_nxt = ADDR;
      oe_nxt    = 1'b0;
      req_nxt   = 1'b0;
      pend_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: begin
          if (ev_h_fall) addr_nxt[31:16] = ad_ev;
          if (ev_l_fall) begin
            addr_nxt[15:0] = {ad_ev[15:1], 1'b0};
            start_fetch    = 1'b1;
          end
        end
        FETCH: begin
          if (ev_r_fall) pend_nxt = 1'b1;
          if (rom_ack) begin
            req_nxt  = 1'b0;
            data_nxt = rom_data;
            pend_nxt = 1'b0;
            if (read_pend || ev_r_fall) begin
              ad_o_nxt  = rom_data;
              oe_nxt    = 1'b1;
              late_nxt  = 1'b1;
              state_nxt = DRIVE;
            end else begin
              state_nxt = READY;
            end
          end
        end
        READY: begin
          if (ev_r_fall) begin
            ad_o_nxt  = data_reg;
            oe_nxt    = 1'b1;
            state_nxt = DRIVE;
          end
        end
        DRIVE: begin
          if (ev_r_rise) begin
            oe_nxt      = 1'b0;
            addr_nxt    = addr + 32'd2;
            start_fetch = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (start_fetch) begin
`ifdef N64_PI_RANGE_CHECK_EN
      if (in_window(addr_nxt)) begin
        rom_addr_nxt = addr_nxt - ROM_BASE;
        req_nxt      = 1'b1;
        state_nxt    = FETCH;
      end else begin
        data_nxt  = '0;
        req_nxt   = 1'b0;
        state_nxt = READY;
      end
`else
      rom_addr_nxt = addr_nxt;
      req_nxt      = 1'b1;
      state_nxt    = FETCH;
`endif
    end
  end

endmodule
